// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-pattern detector.
// Samples one bit per qualified clock and compares the last PAT_W bits against
// a run-time reloadable pattern register. It emits a registered one-cycle match
// pulse and supports overlapping and non-overlapping detection.
// Optional feature macro: SEQDET_CNT_EN builds a saturating match counter.
// When the macro is undefined, match_cnt is tied to 0.
module seq_detector_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             aa,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    output logic             ww,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_q
);

    // Wide enough to hold the value PAT_W itself (fill saturates there).
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d, hist_sh;
    logic [PAT_W-1:0] pat_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW:0]      fill_inc;
    logic             ww_q, ww_d;
    logic             full;

    // Shift aa in as the newest bit. The truncating cast drops the oldest bit,
    // which also covers PAT_W=1, where the history is just aa.
    assign hist_sh  = PAT_W'({hist_q, aa});
    assign fill_inc = {1'b0, fill_q} + 1'b1;
    assign full     = (fill_inc >= (FW+1)'(PAT_W));

    // Next-state logic: a pattern load wins over sampling, and an idle edge
    // holds the history.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        ww_d   = 1'b0;
        if (pat_ld) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_sh;
            if (full) fill_d = FW'(PAT_W);
            else      fill_d = fill_inc[FW-1:0];
            if (full && (hist_sh == pat_q)) begin
                ww_d = 1'b1;
                // Non-overlapping: the next match needs PAT_W fresh bits.
                if (!overlap) fill_d = '0;
            end
        end
    end

    // State registers with synchronous reset, which discards partial history.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            ww_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            ww_q   <= ww_d;
        end
    end

    assign ww = ww_q;

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating detection count. Only reset clears it; a pattern load does not.
    always_comb begin
        cnt_d = cnt_q;
        if (ww_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed streams plus randomized traffic,
// checked against a queue-based behavioural model. Two instances share all
// inputs: the default CNT_W=8 instance, and a CNT_W=2 instance that exercises
// counter saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, aa, en, overlap, pat_ld;
    logic [2:0] pat_in;
    logic       ww, ww2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [2:0] pat_q, pat_q2;

    int n_chk = 0;
    int n_err = 0;
    int npulse;

    // Behavioural model: the valid bits seen since the last flush.
    bit         mbits[$];
    logic [2:0] mpat;
    logic       mww;
    int         mcnt, mcnt2;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .aa(aa), .en(en), .overlap(overlap),
        .pat_ld(pat_ld), .pat_in(pat_in), .ww(ww), .match_cnt(match_cnt),
        .pat_q(pat_q)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .aa(aa), .en(en), .overlap(overlap),
        .pat_ld(pat_ld), .pat_in(pat_in), .ww(ww2), .match_cnt(match_cnt2),
        .pat_q(pat_q2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the rules of the block.
    task automatic model_edge(input bit r, input bit a, input bit e, input bit ov,
                              input bit ld, input logic [2:0] pin);
        mww = 1'b0;
        if (r) begin
            mbits.delete();
            mpat = 3'b110;
            mcnt = 0;
            mcnt2 = 0;
        end else if (ld) begin
            mpat = pin;
            mbits.delete();
        end else if (e) begin
            mbits.push_back(a);
            if (mbits.size() > 3) void'(mbits.pop_front());
            if (mbits.size() == 3 && {mbits[0], mbits[1], mbits[2]} == mpat) begin
                mww = 1'b1;
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
                if (!ov) mbits.delete();
            end
        end
    endtask

    // Drive one cycle, then compare both instances against the model.
    task automatic step(input bit r, input bit a, input bit e, input bit ov,
                        input bit ld, input logic [2:0] pin);
        int ec, ec2;
        rst = r; aa = a; en = e; overlap = ov; pat_ld = ld; pat_in = pin;
        @(posedge clk);
        model_edge(r, a, e, ov, ld, pin);
        #1;
`ifdef SEQDET_CNT_EN
        ec = mcnt; ec2 = mcnt2;
`else
        ec = 0; ec2 = 0;
`endif
        chk("ww", {31'b0, ww}, {31'b0, mww});
        chk("pat_q", {29'b0, pat_q}, {29'b0, mpat});
        chk("match_cnt", {24'b0, match_cnt}, ec);
        chk("ww2", {31'b0, ww2}, {31'b0, mww});
        chk("match_cnt2", {30'b0, match_cnt2}, ec2);
        if (ww === 1'b1) npulse++;
    endtask

    task automatic feed(input bit a, input bit ov);
        step(0, a, 1, ov, 0, 3'b000);
    endtask

    initial begin
        bit s7[7] = '{0, 1, 1, 0, 1, 1, 0};
        bit s5[5] = '{1, 0, 1, 0, 1};
        rst = 1; aa = 0; en = 0; overlap = 1; pat_ld = 0; pat_in = 0;
        npulse = 0;
        step(1, 0, 0, 1, 0, 3'b000);
        step(1, 0, 0, 1, 0, 3'b000);

        // Default pattern, overlapping: 0110110 gives two pulses.
        npulse = 0;
        foreach (s7[i]) feed(s7[i], 1);
        chk("t1_pulses", npulse, 2);
`ifdef SEQDET_CNT_EN
        chk("t1_cnt", {24'b0, match_cnt}, 2);
`endif

        // Pattern 101, overlapping and then non-overlapping.
        step(0, 0, 0, 1, 1, 3'b101);
        npulse = 0;
        foreach (s5[i]) feed(s5[i], 1);
        chk("t2_ovl_pulses", npulse, 2);
        step(0, 0, 0, 0, 1, 3'b101);
        npulse = 0;
        foreach (s5[i]) feed(s5[i], 0);
        chk("t2_novl_pulses", npulse, 1);

        // An idle gap holds the history.
        step(1, 0, 0, 1, 0, 3'b000);
        npulse = 0;
        feed(1, 1); feed(1, 1);
        for (int i = 0; i < 5; i++) step(0, i[0], 0, 1, 0, 3'b000);
        chk("t3_idle_pulses", npulse, 0);
        feed(0, 1);
        chk("t3_resume_pulses", npulse, 1);

        // A load on a qualified edge flushes the history and drops aa.
        npulse = 0;
        feed(1, 1); feed(1, 1);
        step(0, 0, 1, 1, 1, 3'b110);
        chk("t4_load_pulses", npulse, 0);
        feed(1, 1); feed(1, 1); feed(0, 1);
        chk("t4_after_pulses", npulse, 1);

        // Counter saturation on the CNT_W=2 instance: 1,2,3,3,3.
        step(1, 0, 0, 1, 0, 3'b000);
        for (int k = 0; k < 5; k++) begin
            feed(1, 1); feed(1, 1); feed(0, 1);
`ifdef SEQDET_CNT_EN
            chk("t5_cnt2", {30'b0, match_cnt2}, (k < 3) ? k + 1 : 3);
`else
            chk("t5_cnt2_off", {30'b0, match_cnt2}, 0);
`endif
        end

        // A reset mid-stream discards the history.
        step(1, 0, 0, 1, 0, 3'b000);
        feed(1, 1); feed(1, 1);
        step(1, 0, 1, 1, 0, 3'b000);
        chk("t6_rst_ww", {31'b0, ww}, 0);
        chk("t6_rst_pat", {29'b0, pat_q}, 3'b110);
        npulse = 0;
        feed(0, 1);
        chk("t6_zero_pulses", npulse, 0);
        feed(1, 1); feed(1, 1); feed(0, 1);
        chk("t6_full_pulses", npulse, 1);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, ld;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 39) == 0);
            step(r, $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ld, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
